// File: rtl/mcu_32x.sv
// mcu_32x: single-cycle 32-bit micro-controller core with an internal
// 16-word program ROM and a 16-word data RAM. Every rising clock edge
// executes one instruction. The registered outputs show what that
// instruction did.
module mcu_32x (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] result,
    output logic [31:0] address,
    output logic        mem_read,
    output logic        mem_write
);

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h06;
    localparam logic [5:0] OP_LW   = 6'h07;
    localparam logic [5:0] OP_SW   = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h09;
    localparam logic [5:0] OP_JMP  = 6'h0A;
    localparam logic [5:0] OP_HALT = 6'h3F;

    // The rs2 field overlaps imm[15:14]. Instruction words are formed by
    // OR-ing the fields, exactly as the decoder reads them back.
    function automatic logic [31:0] enc(input logic [5:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2,
                                        input logic [15:0] imm);
        enc = {op, rd, rs1, rs2, 14'd0} | {16'd0, imm};
    endfunction

    logic [3:0]  r_pc;
    logic        r_halted;
    logic [31:0] r_regs [16];
    logic [31:0] r_ram  [16];

    logic [31:0] w_instr;
    logic [5:0]  w_op;
    logic [3:0]  w_rd;
    logic [3:0]  w_rs1;
    logic [3:0]  w_rs2;
    logic [31:0] w_imm;
    logic [31:0] w_rs1v;
    logic [31:0] w_rs2v;
    logic [3:0]  w_ea;
    logic [3:0]  w_next_pc;
    logic        w_reg_we;
    logic        w_ram_we;
    logic        w_halt;
    logic [31:0] w_result;
    logic [31:0] w_address;
    logic        w_mem_rd;
    logic        w_mem_wr;

    // Fixed program ROM. Words 12-15 are NOP.
    always_comb begin
        w_instr = enc(OP_NOP, 4'd0, 4'd0, 4'd0, 16'd0);
        case (r_pc)
            4'd0:  w_instr = enc(OP_ADDI, 4'd1, 4'd0, 4'd0, 16'd5);
            4'd1:  w_instr = enc(OP_ADDI, 4'd2, 4'd0, 4'd0, 16'd3);
            4'd2:  w_instr = enc(OP_ADD,  4'd3, 4'd1, 4'd2, 16'd0);
            4'd3:  w_instr = enc(OP_SUB,  4'd4, 4'd1, 4'd2, 16'd0);
            4'd4:  w_instr = enc(OP_AND,  4'd5, 4'd1, 4'd2, 16'd0);
            4'd5:  w_instr = enc(OP_OR,   4'd6, 4'd1, 4'd2, 16'd0);
            4'd6:  w_instr = enc(OP_XOR,  4'd7, 4'd1, 4'd2, 16'd0);
            4'd7:  w_instr = enc(OP_SW,   4'd0, 4'd0, 4'd3, 16'd4);
            4'd8:  w_instr = enc(OP_LW,   4'd8, 4'd0, 4'd0, 16'd4);
            4'd9:  w_instr = enc(OP_BEQ,  4'd0, 4'd3, 4'd8, 16'd1);
            4'd10: w_instr = enc(OP_ADDI, 4'd9, 4'd0, 4'd0, 16'd1);
            4'd11: w_instr = enc(OP_HALT, 4'd0, 4'd0, 4'd0, 16'd0);
            default: w_instr = enc(OP_NOP, 4'd0, 4'd0, 4'd0, 16'd0);
        endcase
    end

    // Field extraction and register-file reads. r0 always reads as zero.
    always_comb begin
        w_op   = w_instr[31:26];
        w_rd   = w_instr[25:22];
        w_rs1  = w_instr[21:18];
        w_rs2  = w_instr[17:14];
        w_imm  = {{16{w_instr[15]}}, w_instr[15:0]};
        w_rs1v = (w_rs1 == 4'd0) ? 32'd0 : r_regs[w_rs1];
        w_rs2v = (w_rs2 == 4'd0) ? 32'd0 : r_regs[w_rs2];
        w_ea   = w_rs1v[3:0] + w_imm[3:0];
    end

    // Execute: the ALU, the next PC, write enables and the next output values.
    always_comb begin
        w_next_pc = r_pc + 4'd1;
        w_reg_we  = 1'b0;
        w_ram_we  = 1'b0;
        w_halt    = 1'b0;
        w_result  = 32'd0;
        w_address = {28'd0, r_pc};
        w_mem_rd  = 1'b0;
        w_mem_wr  = 1'b0;
        case (w_op)
            OP_ADD:  begin w_result = w_rs1v + w_rs2v; w_reg_we = 1'b1; end
            OP_SUB:  begin w_result = w_rs1v - w_rs2v; w_reg_we = 1'b1; end
            OP_AND:  begin w_result = w_rs1v & w_rs2v; w_reg_we = 1'b1; end
            OP_OR:   begin w_result = w_rs1v | w_rs2v; w_reg_we = 1'b1; end
            OP_XOR:  begin w_result = w_rs1v ^ w_rs2v; w_reg_we = 1'b1; end
            OP_ADDI: begin w_result = w_rs1v + w_imm;  w_reg_we = 1'b1; end
            OP_LW: begin
                w_result  = r_ram[w_ea];
                w_reg_we  = 1'b1;
                w_address = {28'd0, w_ea};
                w_mem_rd  = 1'b1;
            end
            OP_SW: begin
                w_result  = w_rs2v;
                w_ram_we  = 1'b1;
                w_address = {28'd0, w_ea};
                w_mem_wr  = 1'b1;
            end
            OP_BEQ: begin
                w_result = w_rs1v - w_rs2v;
                if (w_rs1v == w_rs2v)
                    w_next_pc = r_pc + 4'd1 + w_imm[3:0];
            end
            OP_JMP:  w_next_pc = w_imm[3:0];
            OP_HALT: begin
                w_next_pc = r_pc;
                w_halt    = 1'b1;
            end
            default: ;
        endcase
    end

    // Architectural state and registered outputs. While halted, only the
    // frozen halt status is presented.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= 4'd0;
            r_halted  <= 1'b0;
            result    <= 32'd0;
            address   <= 32'd0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_regs[i] <= 32'd0;
                r_ram[i]  <= 32'd0;
            end
        end else if (r_halted) begin
            result    <= 32'd0;
            address   <= {28'd0, r_pc};
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            r_pc      <= w_next_pc;
            r_halted  <= w_halt;
            result    <= w_result;
            address   <= w_address;
            mem_read  <= w_mem_rd;
            mem_write <= w_mem_wr;
            if (w_reg_we && (w_rd != 4'd0))
                r_regs[w_rd] <= w_result;
            if (w_ram_we)
                r_ram[w_ea] <= w_rs2v;
        end
    end

endmodule

// File: tb/tb_mcu_32x.sv
// Directed testbench for mcu_32x. It checks the program trace, the halt
// behaviour and reset taken in the middle of the program.
module tb_mcu_32x;

    logic        clk;
    logic        reset;
    logic [31:0] result;
    logic [31:0] address;
    logic        mem_read;
    logic        mem_write;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic [31:0] addr;
        logic        rd;
        logic        wr;
    } vec_t;

    vec_t vecs [20];

    mcu_32x dut (
        .clk       (clk),
        .reset     (reset),
        .result    (result),
        .address   (address),
        .mem_read  (mem_read),
        .mem_write (mem_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] exp_res,
                         input logic [31:0] exp_addr, input logic exp_rd,
                         input logic exp_wr);
        checks++;
        if (result !== exp_res || address !== exp_addr ||
            mem_read !== exp_rd || mem_write !== exp_wr ||
            (mem_read === 1'b1 && mem_write === 1'b1)) begin
            errors++;
            $display("FAIL %s: got res=%0d addr=%0d rd=%b wr=%b, want res=%0d addr=%0d rd=%b wr=%b",
                     name, result, address, mem_read, mem_write,
                     exp_res, exp_addr, exp_rd, exp_wr);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [31:0] r, input logic [31:0] a,
                                input logic rd, input logic wr);
        vec_t v;
        v.res = r; v.addr = a; v.rd = rd; v.wr = wr;
        return v;
    endfunction

    initial begin
        vecs[0]  = mk(32'd5, 32'd0, 1'b0, 1'b0);
        vecs[1]  = mk(32'd3, 32'd1, 1'b0, 1'b0);
        vecs[2]  = mk(32'd8, 32'd2, 1'b0, 1'b0);
        vecs[3]  = mk(32'd2, 32'd3, 1'b0, 1'b0);
        vecs[4]  = mk(32'd1, 32'd4, 1'b0, 1'b0);
        vecs[5]  = mk(32'd7, 32'd5, 1'b0, 1'b0);
        vecs[6]  = mk(32'd6, 32'd6, 1'b0, 1'b0);
        vecs[7]  = mk(32'd8, 32'd4, 1'b0, 1'b1);
        vecs[8]  = mk(32'd8, 32'd4, 1'b1, 1'b0);
        vecs[9]  = mk(32'd0, 32'd9, 1'b0, 1'b0);
        vecs[10] = mk(32'd0, 32'd11, 1'b0, 1'b0);
        for (int i = 11; i < 20; i++)
            vecs[i] = mk(32'd0, 32'd11, 1'b0, 1'b0);

        // Assert reset asynchronously, then hold it for three edges.
        reset = 1'b1;
        #1 reset = 1'b0;
        #1 check("reset_async", 32'd0, 32'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("reset_hold_%0d", i), 32'd0, 32'd0, 1'b0, 1'b0);
        end

        // Release reset and run the whole program into the halt.
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("edge_%0d", i + 1), vecs[i].res, vecs[i].addr,
                  vecs[i].rd, vecs[i].wr);
        end

        // Restart from reset, then abort between edges 5 and 6.
        @(negedge clk) reset = 1'b0;
        #1 check("halt_reset_async", 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rerun_edge_%0d", i + 1), vecs[i].res, vecs[i].addr,
                  vecs[i].rd, vecs[i].wr);
        end
        #2 reset = 1'b0;
        #1 check("mid_reset_async", 32'd0, 32'd0, 1'b0, 1'b0);
        step();
        check("mid_reset_hold", 32'd0, 32'd0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("restart_edge_%0d", i + 1), vecs[i].res, vecs[i].addr,
                  vecs[i].rd, vecs[i].wr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "timeout");
    end

endmodule
